// File: rtl/alu_mul_sequencer_pkg.sv
// Shared definitions for the shift-add multiplier sequencer: FSM states,
// ALU function-select codes and ALU flag bit positions.
package alu_mul_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EVAL,
        ST_ADD,
        ST_SHMC,
        ST_SHMP,
        ST_DONE
    } state_t;

    localparam logic [3:0] FUN_ADD = 4'b0100;
    localparam logic [3:0] FUN_LSL = 4'b1011;
    localparam logic [3:0] FUN_LSR = 4'b1100;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_O = 0;

    function automatic logic [4:0] width_count(input logic w16);
        return w16 ? 5'd16 : 5'd8;
    endfunction

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier that borrows an external ALU for every add and shift.
// Build option MULSEQ_EARLY_EXIT_EN: finish as soon as no multiplier bits remain.
module alu_mul_sequencer
    import alu_mul_sequencer_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Width16,
    input  logic [15:0] Multiplicand,
    input  logic [15:0] Multiplier,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] Product,
    output logic        Overflow,
    output logic [15:0] AluA,
    output logic [15:0] AluB,
    output logic [4:0]  AluFunSel,
    output logic        AluWF,
    input  logic [15:0] AluOut,
    input  logic [3:0]  AluFlags
);

    state_t      state_reg, state_next;
    logic [15:0] acc_reg, acc_next;
    logic [15:0] mcand_reg, mcand_next;
    logic [15:0] mplier_reg, mplier_next;
    logic [15:0] product_reg, product_next;
    logic [4:0]  count_reg, count_next;
    logic        w16_reg, w16_next;
    logic        overflow_reg, overflow_next;
    logic        prev_add_reg, prev_add_next;
    logic [15:0] width_mask;
    logic [15:0] alu_out_masked;
    logic        iter_done;
    logic        unused_flags;

    assign unused_flags = ^{AluFlags[FLAG_Z], AluFlags[FLAG_N], AluFlags[FLAG_O]};

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            acc_reg      <= 16'h0000;
            mcand_reg    <= 16'h0000;
            mplier_reg   <= 16'h0000;
            product_reg  <= 16'h0000;
            count_reg    <= 5'd0;
            w16_reg      <= 1'b0;
            overflow_reg <= 1'b0;
            prev_add_reg <= 1'b0;
        end else begin
            acc_reg      <= acc_next;
            mcand_reg    <= mcand_next;
            mplier_reg   <= mplier_next;
            product_reg  <= product_next;
            count_reg    <= count_next;
            w16_reg      <= w16_next;
            overflow_reg <= overflow_next;
            prev_add_reg <= prev_add_next;
        end
    end

    // ALU results are clipped to the active width so an 8-bit run never leaks upper bits.
    assign width_mask     = w16_reg ? 16'hFFFF : 16'h00FF;
    assign alu_out_masked = AluOut & width_mask;

    always_comb begin
        state_next    = state_reg;
        acc_next      = acc_reg;
        mcand_next    = mcand_reg;
        mplier_next   = mplier_reg;
        product_next  = product_reg;
        count_next    = count_reg;
        w16_next      = w16_reg;
        overflow_next = overflow_reg;
        prev_add_next = (state_reg == ST_ADD);
        AluA          = 16'h0000;
        AluB          = 16'h0000;
        AluFunSel     = 5'b00000;
        AluWF         = 1'b0;
`ifdef MULSEQ_EARLY_EXIT_EN
        iter_done     = (count_reg == width_count(w16_reg)) || (mplier_reg == 16'h0000);
`else
        iter_done     = (count_reg == width_count(w16_reg));
`endif

        case (state_reg)
            ST_IDLE: begin
                if (Start) begin
                    acc_next      = 16'h0000;
                    count_next    = 5'd0;
                    overflow_next = 1'b0;
                    w16_next      = Width16;
                    mcand_next    = Width16 ? Multiplicand : {8'h00, Multiplicand[7:0]};
                    mplier_next   = Width16 ? Multiplier : {8'h00, Multiplier[7:0]};
                    state_next    = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (iter_done) begin
                    // Load on entry to DONE so Product is already valid while Done is high.
                    product_next = acc_reg & width_mask;
                    state_next   = ST_DONE;
                end else if (mplier_reg[0]) begin
                    state_next = ST_ADD;
                end else begin
                    state_next = ST_SHMC;
                end
            end
            ST_ADD: begin
                AluA       = acc_reg;
                AluB       = mcand_reg;
                AluFunSel  = {w16_reg, FUN_ADD};
                AluWF      = 1'b1;
                acc_next   = alu_out_masked;
                state_next = ST_SHMC;
            end
            ST_SHMC: begin
                AluA       = mcand_reg;
                AluFunSel  = {w16_reg, FUN_LSL};
                AluWF      = 1'b1;
                mcand_next = alu_out_masked;
                // Flags here still describe the add of the previous cycle.
                if (prev_add_reg && AluFlags[FLAG_C]) begin
                    overflow_next = 1'b1;
                end
                state_next = ST_SHMP;
            end
            ST_SHMP: begin
                AluA        = mplier_reg;
                AluFunSel   = {w16_reg, FUN_LSR};
                AluWF       = 1'b1;
                mplier_next = alu_out_masked;
                count_next  = count_reg + 5'd1;
                // A multiplicand bit just fell off while higher multiplier bits remain.
                if (AluFlags[FLAG_C] && (alu_out_masked != 16'h0000)) begin
                    overflow_next = 1'b1;
                end
                state_next = ST_EVAL;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign Busy     = (state_reg != ST_IDLE);
    assign Done     = (state_reg == ST_DONE);
    assign Product  = product_reg;
    assign Overflow = overflow_reg;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Randomized scoreboard bench for alu_mul_sequencer with a behavioural ALU attached;
// honours MULSEQ_EARLY_EXIT_EN when computing expected latency.
module tb_alu_mul_sequencer;

    logic        Clock;
    logic        Reset;
    logic        Start;
    logic        Width16;
    logic [15:0] Multiplicand;
    logic [15:0] Multiplier;
    logic        Busy;
    logic        Done;
    logic [15:0] Product;
    logic        Overflow;
    logic [15:0] AluA;
    logic [15:0] AluB;
    logic [4:0]  AluFunSel;
    logic        AluWF;
    logic [15:0] AluOut;
    logic [3:0]  AluFlags;

    alu_mul_sequencer dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Start        (Start),
        .Width16      (Width16),
        .Multiplicand (Multiplicand),
        .Multiplier   (Multiplier),
        .Busy         (Busy),
        .Done         (Done),
        .Product      (Product),
        .Overflow     (Overflow),
        .AluA         (AluA),
        .AluB         (AluB),
        .AluFunSel    (AluFunSel),
        .AluWF        (AluWF),
        .AluOut       (AluOut),
        .AluFlags     (AluFlags)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    // Behavioural ALU: combinational result, ZCNO flags captured when AluWF is set.
    logic [3:0] flags_next;
    logic [8:0] sum8;
    logic [16:0] sum16;
    always_comb begin
        AluOut     = 16'h0000;
        flags_next = 4'h0;
        sum8       = {1'b0, AluA[7:0]} + {1'b0, AluB[7:0]};
        sum16      = {1'b0, AluA} + {1'b0, AluB};
        case (AluFunSel[3:0])
            4'b0100: begin
                AluOut        = AluFunSel[4] ? sum16[15:0] : {8'h00, sum8[7:0]};
                flags_next[2] = AluFunSel[4] ? sum16[16] : sum8[8];
            end
            4'b1011: begin
                AluOut        = AluFunSel[4] ? {AluA[14:0], 1'b0} : {8'h00, AluA[6:0], 1'b0};
                flags_next[2] = AluFunSel[4] ? AluA[15] : AluA[7];
            end
            4'b1100: begin
                AluOut        = AluFunSel[4] ? {1'b0, AluA[15:1]} : {9'h000, AluA[7:1]};
                flags_next[2] = AluA[0];
            end
            default: begin
                AluOut = 16'h0000;
            end
        endcase
        flags_next[3] = (AluOut == 16'h0000);
        flags_next[1] = AluFunSel[4] ? AluOut[15] : AluOut[7];
    end

    always @(posedge Clock) begin
        if (AluWF) AluFlags <= flags_next;
    end

    typedef struct {
        logic        w16;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] product;
        logic        ovf;
        int          latency;
        int          start_cyc;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int n_txn = 0;
    logic [15:0] last_product = 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Reference: plain integer multiply; latency from iteration count and multiplier bits.
    function automatic exp_t model(input logic w16, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        longint unsigned aa, bb, full;
        int w, iters;
        w    = w16 ? 16 : 8;
        aa   = w16 ? {48'h0, a} : {56'h0, a[7:0]};
        bb   = w16 ? {48'h0, b} : {56'h0, b[7:0]};
        full = aa * bb;
        e.w16     = w16;
        e.a       = a;
        e.b       = b;
        e.product = w16 ? full[15:0] : {8'h00, full[7:0]};
        e.ovf     = ((full >> w) != 0);
        iters     = w;
`ifdef MULSEQ_EARLY_EXIT_EN
        iters = 0;
        for (int k = 0; k < w; k++) if (bb[k]) iters = k + 1;
`endif
        e.latency = 2;
        for (int k = 0; k < iters; k++) e.latency += 3 + int'(bb[k]);
        e.start_cyc = 0;
        return e;
    endfunction

    always @(negedge Clock) begin : monitor
        exp_t e;
        if (Reset && Done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got Done=1, required no Done (queue empty)");
            end else begin
                e = exp_q.pop_front();
                n_txn++;
                $display("txn %0d: w16=%0d 0x%04h*0x%04h -> product=0x%04h ovf=%0d lat=%0d (exp 0x%04h %0d %0d)",
                         n_txn, e.w16, e.a, e.b, Product, Overflow, cyc - e.start_cyc,
                         e.product, e.ovf, e.latency);
                check("product", 32'(Product), 32'(e.product));
                check("overflow", 32'(Overflow), 32'(e.ovf));
                check("latency", 32'(cyc - e.start_cyc), 32'(e.latency));
                check("alu_idle_at_done", {AluA, AluB}, 32'h0);
                check("alu_ctl_at_done", 32'({AluFunSel, AluWF}), 32'h0);
                last_product = e.product;
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (Busy && t < 300) begin
            @(negedge Clock);
            t++;
        end
        if (Busy) check("idle_timeout", 32'(Busy), 32'h0);
    endtask

    task automatic run_op(input logic w16, input logic [15:0] a, input logic [15:0] b,
                          input logic pulse_busy);
        exp_t e;
        wait_idle();
        check("alu_zero_in_idle", 32'({AluFunSel, AluWF}), 32'h0);
        Start        = 1'b1;
        Width16      = w16;
        Multiplicand = a;
        Multiplier   = b;
        e            = model(w16, a, b);
        e.start_cyc  = cyc;
        exp_q.push_back(e);
        @(negedge Clock);
        Start = 1'b0;
        if (pulse_busy) begin
            check("busy_after_start", 32'(Busy), 32'h1);
            Start        = 1'b1;
            Width16      = ~w16;
            Multiplicand = 16'($urandom);
            Multiplier   = 16'($urandom);
            @(negedge Clock);
            Start = 1'b0;
        end
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic        rw;
        int          t;
        Reset        = 1'b0;
        Start        = 1'b0;
        Width16      = 1'b0;
        Multiplicand = 16'h0000;
        Multiplier   = 16'h0000;
        repeat (2) @(negedge Clock);
        check("reset_busy", 32'(Busy), 32'h0);
        check("reset_done", 32'(Done), 32'h0);
        check("reset_product", 32'(Product), 32'h0);
        check("reset_overflow", 32'(Overflow), 32'h0);
        Reset = 1'b1;
        @(negedge Clock);

        run_op(1'b1, 16'h0003, 16'h0005, 1'b0);
        run_op(1'b1, 16'h1234, 16'h0000, 1'b0);
        run_op(1'b0, 16'h0012, 16'h0010, 1'b0);
        run_op(1'b0, 16'hAB03, 16'hCD04, 1'b0);
        run_op(1'b1, 16'hFFFF, 16'h0001, 1'b0);
        run_op(1'b1, 16'h8000, 16'h0002, 1'b0);
        run_op(1'b0, 16'h00FF, 16'h00FF, 1'b0);
        run_op(1'b1, 16'h00FF, 16'h0101, 1'b1);

        // Reset in the middle of a multiplicand shift: the run is abandoned silently.
        run_op(1'b1, 16'h1357, 16'h0F0F, 1'b0);
        t = 0;
        while (!(AluWF && AluFunSel[3:0] == 4'b1011) && t < 100) begin
            @(negedge Clock);
            t++;
        end
        check("reach_shmc", 32'(AluFunSel[3:0]), 32'hB);
        #1 Reset = 1'b0;
        #1;
        check("midrun_reset_busy", 32'(Busy), 32'h0);
        check("midrun_reset_done", 32'(Done), 32'h0);
        check("midrun_reset_product", 32'(Product), 32'h0);
        check("midrun_reset_overflow", 32'(Overflow), 32'h0);
        exp_q.delete();
        @(negedge Clock);
        Reset = 1'b1;
        repeat (80) @(negedge Clock);
        run_op(1'b1, 16'h0003, 16'h0005, 1'b0);

        for (int i = 0; i < 40; i++) begin
            rw = 1'($urandom_range(0, 1));
            ra = 16'($urandom);
            rb = 16'($urandom);
            case ($urandom_range(0, 3))
                0: rb = rb & 16'h000F;
                1: rb = 16'h0001 << $urandom_range(0, 15);
                2: ra = ra & 16'h00FF;
                default: ;
            endcase
            run_op(rw, ra, rb, 1'($urandom_range(0, 4) == 0));
        end

        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge Clock);
            t++;
        end
        check("drain_queue", 32'(exp_q.size()), 32'h0);
        repeat (3) @(negedge Clock);
        check("product_hold", 32'(Product), 32'(last_product));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
